timer_ctrl: RTL and testbench



---
 rtl/timer_pkg.sv | 21 ++
 rtl/timer_if.sv | 10 +
 rtl/timer_prescaler.sv | 32 +++
 rtl/timer_ctrl.sv | 92 +++++++++
 tb/tb_timer_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared types and command codes for the timer peripheral controller.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [2:0] TIM_ENABLE   = 3'b000;
  localparam logic [2:0] TIM_PSC_I    = 3'b001;
  localparam logic [2:0] TIM_ARR_I    = 3'b010;
  localparam logic [2:0] TIM_CLR_FLAG = 3'b011;
  localparam logic [2:0] TIM_PSC_REG  = 3'b100;
  localparam logic [2:0] TIM_ARR_REG  = 3'b101;
  localparam logic [2:0] TIM_READ_CNT = 3'b110;
  localparam logic [2:0] TIM_DISABLE  = 3'b111;

  localparam logic [6:0] TIM_OPCODE = 7'b0100101;

endpackage

// File: rtl/timer_if.sv
// Command bus from the control unit into the timer controller.
interface timer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/timer_prescaler.sv
// Prescaler: counts 0..psc_act and emits one tick per wrap; active value reloads on clr/load.
module timer_prescaler #(
  parameter int PSC_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [PSC_W-1:0] load_val,
  output logic             tick
);

  logic [PSC_W-1:0] psc_cnt;
  logic [PSC_W-1:0] psc_act;

  assign tick = en && (psc_cnt == psc_act);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psc_cnt <= '0;
      psc_act <= '0;
    end else if (clr) begin
      psc_cnt <= '0;
      psc_act <= load_val;
    end else if (en) begin
      psc_cnt <= tick ? '0 : psc_cnt + 1'b1;
      if (load) psc_act <= load_val;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// Timer controller: command decode, IDLE/ARM/RUN sequencing, main counter with
// preloaded PSC/ARR shadows, sticky update flag, interrupt pulse and counter read-back.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PSC_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  timer_if.slave           bus,
  output logic [CNT_W-1:0] cnt_o,
  output logic             running_o,
  output logic             uif_o,
  output logic             irq_o,
  output logic [31:0]      rdata_o,
  output logic             rvalid_o
);

  state_t           state_q, state_d;
  logic [PSC_W-1:0] psc_shadow;
  logic [CNT_W-1:0] arr_shadow, arr_act, cnt;
  logic             cmd_fire, tick, evt;

  assign bus.cmd_ready = (state_q != ARM);
  assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
  assign running_o     = (state_q == ARM) || (state_q == RUN);
  assign cnt_o         = cnt;

  // ARR of zero parks the counter at 0 and never produces an update event
  assign evt = tick && (arr_act != '0) && (cnt == arr_act);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_fire && bus.cmd_op == TIM_ENABLE)  state_d = ARM;
      ARM:     state_d = RUN;
      RUN:     if (cmd_fire && bus.cmd_op == TIM_DISABLE) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  timer_prescaler #(.PSC_W(PSC_W)) u_psc (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (state_q == RUN),
    .clr      (state_q == ARM),
    .load     (evt),
    .load_val (psc_shadow),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psc_shadow <= '0;
      arr_shadow <= '0;
      arr_act    <= '0;
      cnt        <= '0;
      uif_o      <= 1'b0;
      irq_o      <= 1'b0;
      rdata_o    <= '0;
      rvalid_o   <= 1'b0;
    end else begin
      // Active registers sample the shadows before this cycle's writes land
      if (cmd_fire && (bus.cmd_op == TIM_PSC_I || bus.cmd_op == TIM_PSC_REG))
        psc_shadow <= bus.cmd_data[PSC_W-1:0];
      if (cmd_fire && (bus.cmd_op == TIM_ARR_I || bus.cmd_op == TIM_ARR_REG))
        arr_shadow <= bus.cmd_data[CNT_W-1:0];

      if (state_q == ARM) begin
        cnt     <= '0;
        arr_act <= arr_shadow;
      end else begin
        if (tick) cnt <= (cnt == arr_act) ? '0 : cnt + 1'b1;
        if (evt)  arr_act <= arr_shadow;
      end

      if (evt)                                         uif_o <= 1'b1;
      else if (cmd_fire && bus.cmd_op == TIM_CLR_FLAG) uif_o <= 1'b0;
      irq_o <= evt;

      rvalid_o <= cmd_fire && (bus.cmd_op == TIM_READ_CNT);
      if (cmd_fire && bus.cmd_op == TIM_READ_CNT) rdata_o <= 32'(cnt);
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios then random commands against a period-arithmetic model.
module tb_timer_ctrl;
  import timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] cnt_o;
  logic        running_o, uif_o, irq_o, rvalid_o;
  logic [31:0] rdata_o;

  timer_if bus();

  timer_ctrl #(.CNT_W(32), .PSC_W(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .cnt_o     (cnt_o),
    .running_o (running_o),
    .uif_o     (uif_o),
    .irq_o     (irq_o),
    .rdata_o   (rdata_o),
    .rvalid_o  (rvalid_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: mst 0=IDLE 1=ARM 2=RUN; a period starts at cycle S with active P/A
  int     mst;
  longint t, S, P, A, frozen, psh, ash, rd_e;
  logic   uif_e, irq_e, rv_e;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: got %0d expected %0d", tag, t, obs, exp);
    end
  endtask

  function automatic longint cur_cnt();
    if (mst == 2) return (A == 0) ? 0 : (t - S) / (P + 1);
    return frozen;
  endfunction

  function automatic logic evt_now();
    return (mst == 2) && (A != 0) && ((t + 1 - S) == (P + 1) * (A + 1));
  endfunction

  task automatic model_reset();
    mst = 0; S = 0; P = 0; A = 0; frozen = 0; psh = 0; ash = 0; rd_e = 0;
    uif_e = 1'b0; irq_e = 1'b0; rv_e = 1'b0;
  endtask

  task automatic check_outputs();
    chk("cnt_o", longint'(cnt_o), cur_cnt());
    chk("running_o", longint'(running_o), longint'(mst != 0));
    chk("uif_o", longint'(uif_o), longint'(uif_e));
    chk("irq_o", longint'(irq_o), longint'(irq_e));
    chk("rvalid_o", longint'(rvalid_o), longint'(rv_e));
    chk("rdata_o", longint'(rdata_o), rd_e);
    chk("cmd_ready", longint'(bus.cmd_ready), longint'(mst != 1));
  endtask

  task automatic step(input logic v, input logic [2:0] op, input logic [31:0] d);
    logic   fire, ev;
    longint cnow;
    check_outputs();
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    fire = v && (mst != 1);
    cnow = cur_cnt();
    ev   = evt_now();
    irq_e = ev;
    rv_e  = fire && (op == TIM_READ_CNT);
    if (rv_e) rd_e = cnow;
    if (ev) uif_e = 1'b1;
    else if (fire && op == TIM_CLR_FLAG) uif_e = 1'b0;
    if (mst == 2) begin
      if (ev) begin S = t + 1; P = psh; A = ash; end
      if (fire && op == TIM_DISABLE) begin
        frozen = (A == 0) ? 0 : (t + 1 - S) / (P + 1);
        mst = 0;
      end
    end else if (mst == 1) begin
      mst = 2; S = t + 1; P = psh; A = ash;
    end else if (fire && op == TIM_ENABLE) begin
      mst = 1;
    end
    if (fire && (op == TIM_PSC_I || op == TIM_PSC_REG)) psh = longint'(d[15:0]);
    if (fire && (op == TIM_ARR_I || op == TIM_ARR_REG)) ash = longint'(d);
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, TIM_ENABLE, 32'd0);
  endtask

  task automatic do_reset();
    bus.cmd_valid = 1'b0;
    reset_n = 1'b0;
    #2;
    chk("rst cnt_o", longint'(cnt_o), 0);
    chk("rst running_o", longint'(running_o), 0);
    chk("rst uif_o", longint'(uif_o), 0);
    chk("rst irq_o", longint'(irq_o), 0);
    chk("rst rvalid_o", longint'(rvalid_o), 0);
    chk("rst rdata_o", longint'(rdata_o), 0);
    chk("rst cmd_ready", longint'(bus.cmd_ready), 1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    t++;
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_data  = 32'd0;
    t = 0;
    model_reset();
    do_reset();

    // Fast prescale, ARR=3: event every 4 cycles
    step(1'b1, TIM_PSC_I, 32'd0);
    step(1'b1, TIM_ARR_I, 32'd3);
    step(1'b1, TIM_ENABLE, 32'd0);
    idle(6);
    step(1'b1, TIM_ARR_REG, 32'd7);
    idle(3);
    begin : aim_clr
      int k;
      k = 0;
      while (!evt_now() && k < 100) begin idle(1); k++; end
      chk("clr aim bound", longint'(k < 100), 1);
      step(1'b1, TIM_CLR_FLAG, 32'd0);
    end
    idle(10);
    step(1'b1, TIM_CLR_FLAG, 32'd0);
    begin : aim_read
      int k;
      k = 0;
      while (cur_cnt() != 2 && k < 100) begin idle(1); k++; end
      chk("read aim bound", longint'(k < 100), 1);
      step(1'b1, TIM_READ_CNT, 32'd0);
    end
    step(1'b1, TIM_DISABLE, 32'd0);
    idle(5);
    step(1'b1, TIM_ENABLE, 32'd0);
    step(1'b1, TIM_ENABLE, 32'd0);   // lands in ARM, not accepted
    idle(12);

    // PSC=2, ARR=1 via preload: period 6 after next event
    step(1'b1, TIM_PSC_I, 32'd2);
    step(1'b1, TIM_ARR_I, 32'd1);
    idle(30);
    step(1'b1, TIM_DISABLE, 32'd0);

    // ARR=0 parks the counter; upper PSC bits ignored
    step(1'b1, TIM_ARR_I, 32'd0);
    step(1'b1, TIM_PSC_I, 32'hFFFF_1234);
    step(1'b1, TIM_ENABLE, 32'd0);
    idle(50);
    step(1'b1, TIM_DISABLE, 32'd0);
    step(1'b1, TIM_PSC_I, 32'hABCD_0001);
    step(1'b1, TIM_ARR_I, 32'd2);
    step(1'b1, TIM_ENABLE, 32'd0);
    idle(20);

    // Reset in the middle of RUN
    do_reset();
    step(1'b1, TIM_ARR_I, 32'd2);
    step(1'b1, TIM_ENABLE, 32'd0);
    idle(8);

    // Random command traffic
    for (int i = 0; i < 2000; i++) begin
      logic [2:0]  op;
      logic [31:0] d;
      logic        v;
      v  = ($urandom_range(0, 2) == 0);
      op = 3'($urandom_range(0, 7));
      if (op == TIM_DISABLE && $urandom_range(0, 3) != 0) op = TIM_READ_CNT;
      d = $urandom;
      if (op == TIM_PSC_I || op == TIM_PSC_REG) d[15:0] = 16'($urandom_range(0, 3));
      if (op == TIM_ARR_I || op == TIM_ARR_REG) d = $urandom_range(0, 5);
      step(v, op, d);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
